uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Parametrised next-generation UART transmitter. Supports 5-9 data bits, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits, behind a small ready/valid input FIFO, so the host can queue bytes back-to-back. Sits between the acquisition/command logic and the board UART pin, at the same level as the existing 8N1 transmitter it supersedes.

Parameters:
CLKS_PER_BIT, 54, clocks per serial bit (i_Clock freq / baud); valid range 2..65535.
DATA_BITS, 8, data bits per frame; valid range 5..9.
FIFO_DEPTH, 4, input FIFO entries; power of 2, at least 2.

Ports:
i_Clock  in  1  system clock; all logic on the rising edge.
i_Reset  in  1  synchronous, active-high reset.
i_Tx_DV  in  1  write strobe; accepted only when o_Tx_Ready=1.
i_Tx_Byte  in  DATA_BITS  data word; LSB transmitted first.
o_Tx_Ready  out  1  FIFO not full.
i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
i_Two_Stop  in  1  0: one stop bit, 1: two stop bits.
o_Tx_Serial  out  1  serial line, registered.
o_Tx_Active  out  1  high from the frame pop cycle through the last stop-bit cycle.
o_Tx_Done  out  1  one-cycle pulse per completed frame.
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: single clock i_Clock. Reset i_Reset is synchronous and active-high.
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, state=IDLE, all counters 0.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and the line is high the cycle after reset is sampled. No Done pulse.
- Write handshake: a word is written when i_Tx_DV && o_Tx_Ready at a rising edge. i_Tx_DV while full is ignored (word dropped, no error flag). o_Tx_Ready is derived from the registered count; a simultaneous pop does not make a full FIFO accept a write in that same cycle.
- Simultaneous push and pop (not full, not empty): count unchanged, both take effect.
- State machine:
  - IDLE: line=1. If the FIFO is non-empty: pop, latch word, parity mode and stop-bit setting into frame registers, assert Active, go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: line=data[bit_idx], each bit CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY if mode is 01/10, else STOP.
  - PARITY: even = XOR of the data bits; odd = its inverse. Held CLKS_PER_BIT cycles, then STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT if two stop bits are latched. On the last cycle, go to IDLE, Done=1 next cycle, Active=0 next cycle.
- Latency: an accepted write into an empty FIFO with IDLE state puts the start bit on the line 2 cycles later (push, then pop in IDLE, then registered line).
- Back-to-back frames: exactly 1 idle-high clock between the last stop cycle and the next start bit; Done is high during that gap cycle.
- Config changes on i_Parity_Mode / i_Two_Stop mid-frame do not affect the current frame.
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+P+S), where P is 0/1 and S is 1/2.
- Bit counter: width $clog2(CLKS_PER_BIT); it compares against CLKS_PER_BIT-1 and never wraps past it.

Optional Feature:
Macro: UART_TX_BREAK_EN.
- Defined: adds input i_Break (1 bit).
  - While in IDLE with i_Break=1, the line is driven 0 and the FIFO is not popped.
  - Break asserted mid-frame takes effect only after the current frame's stop bits and Done pulse.
  - On deassertion, the line returns to 1 next cycle. A queued frame may start no earlier than CLKS_PER_BIT cycles later, which guarantees a stop-length mark.
- Undefined: no i_Break port; IDLE always drives 1.

Decomposition:
- Package uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP), parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), and a clog2 helper if the toolchain lacks one.
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by width and depth. Outputs full, empty and count. Read data is visible combinationally at the head.
- The top level holds the FSM, baud counter, bit index and shift register.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8 unless stated):
1. Write 0xA5, parity none, one stop -> start bit at +2 cycles; line pattern 0,1,0,1,0,0,1,0,1,1 with 4 cycles each; Done pulse at cycle 42 after the write; Active high for 40 cycles.
2. Parity even, write 0x07 -> parity bit 1; odd with 0x07 -> 0; two stop bits -> stop high for 8 cycles; Done after 48 line cycles.
3. Burst of 6 writes, one per cycle, FIFO_DEPTH=4 -> Ready low after the 4th queued word; extra writes dropped; frames emitted with a 1-cycle idle gap; count returns to 0; 5 Done pulses (4 FIFO words + 1 popped early).
4. DATA_BITS=5, write 0x1F with upper bits set in the input port -> only 5 ones on the line; frame of 7 bits = 28 cycles.
5. Assert i_Reset during DATA bit 3 with 2 words queued -> line=1 next cycle, count=0, no Done, Ready=1; a subsequent write transmits normally.
6. (UART_TX_BREAK_EN) Assert i_Break for 20 cycles with an empty FIFO -> line=0 for 20 cycles; a word queued during break starts no earlier than 4 cycles after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a combinational head. Full/empty/count come from the registered count,
// so a pop never frees a slot for a write in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5-9 data bits, none/even/odd parity, 1/2 stop bits) fed by a small FIFO.
// Optional line-break input is compiled in with UART_TX_BREAK_EN.
module uart_tx_cfg import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 54,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    input  logic [1:0]                    i_Parity_Mode,
    input  logic                          i_Two_Stop,
`ifdef UART_TX_BREAK_EN
    input  logic                          i_Break,
`endif
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic [2:0]                    o_State
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop2_q, stop2_d;
    logic                 brk_hold_q, brk_hold_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 baud_done;
    logic                 break_req;

`ifdef UART_TX_BREAK_EN
    assign break_req = i_Break;
`else
    assign break_req = 1'b0;
`endif

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .wr_en   (i_Tx_DV),
        .wr_data (i_Tx_Byte),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_Fifo_Count)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        brk_hold_d = brk_hold_q;
        fifo_pop   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // After a break, hold a full bit-time of mark before the next start bit.
                if (break_req) begin
                    brk_hold_d = 1'b1;
                    baud_d     = '0;
                end else if (brk_hold_q) begin
                    if (baud_done) begin
                        brk_hold_d = 1'b0;
                        baud_d     = '0;
                    end else begin
                        baud_d = baud_q + CW'(1);
                    end
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_head;
                    par_en_d   = (i_Parity_Mode == PAR_EVEN) || (i_Parity_Mode == PAR_ODD);
                    par_bit_d  = (^fifo_head) ^ (i_Parity_Mode == PAR_ODD);
                    two_stop_d = i_Two_Stop;
                    baud_d     = '0;
                    bit_idx_d  = '0;
                    stop2_d    = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line register follows the next state so line, Active and Done stay cycle-aligned.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_bit_q;
            STOP:    serial_d = 1'b1;
            default: serial_d = !(break_req && (state_q == IDLE));
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            brk_hold_q <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            brk_hold_q <= brk_hold_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign o_Tx_Ready  = !fifo_full;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_State     = state_q;

endmodule
